led_ram_wr_arb: RTL
===================

Name: led_ram_wr_arb

Overview:
- Write-port controller for the 8x8x4-bit LED frame RAM.
- Shares the RAM's single write port between the light-pen requester, a host requester and an internal clear-screen sweep.
- Converts binary row/col addresses to the RAM's one-hot addresses.
- Generates the RAM's edge-sensitive write strobe: rising edge latches address/data, falling edge commits the write.

Parameters:
- WE_CYCLES, 1, cycles `we` is held high per write (legal values >=1).
- GAP_CYCLES, 1, cycles `we` is held low after the strobe before the next write may start (legal values >=1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pen_req  in  1  light-pen write request; level, held until pen_ack
- pen_row  in  3  pen binary row address
- pen_col  in  3  pen binary column address
- pen_data  in  4  pen pixel value
- pen_ack  out  1  one-cycle pulse: pen write committed
- host_req  in  1  host write request; level, held until host_ack
- host_row  in  3  host binary row address
- host_col  in  3  host binary column address
- host_data  in  4  host pixel value
- host_ack  out  1  one-cycle pulse: host write committed
- clr_start  in  1  one-cycle pulse: fill all 64 cells with clr_data
- clr_data  in  4  fill value, sampled on the accepted clr_start
- clr_busy  out  1  high while a clear is pending or running
- clr_done  out  1  one-cycle pulse after the 64th clear write commits
- ram_data  out  4  to RAM data
- ram_addr_row  out  8  to RAM one-hot row address
- ram_addr_col  out  8  to RAM one-hot column address
- ram_we  out  1  to RAM write enable

Behaviour:
- Reset values (rst sampled high at a clk edge): ram_we=0, ram_addr_row=8'h01, ram_addr_col=8'h01, ram_data=0, all acks/clr_done=0, clr_busy=0, FSM=IDLE, RR pointer favours pen, clear index=0. Reset mid-write aborts with no ack.
- FSM states: IDLE -> SETUP (1 cycle) -> STROBE (WE_CYCLES) -> GAP (GAP_CYCLES) -> IDLE.
- IDLE: select a source and register its address/data to the RAM outputs; they take effect on entry to SETUP.
- SETUP: ram_we=0; outputs are stable.
- STROBE: ram_we=1.
- GAP: ram_we=0.
- Addresses and data are held constant from SETUP through the end of GAP.
- Outside a write, outputs keep their last values.
- ack / clr_done: the pulse is asserted in the last GAP cycle. The requester may drop or change req on the following cycle.
- Latency: with default parameters, req high in cycle 0 (FSM in IDLE) -> ram_we high in cycle 2 -> ack in cycle 3. Back-to-back writes cost 4 cycles each.
- Arbitration is evaluated only in IDLE, in this priority:
  - A pending or active clear has absolute priority; pen and host are stalled (no ack) until clr_done.
  - Otherwise, pen vs host round-robin: if both request, grant the source not granted last; if only one requests, grant it. The pointer updates on each grant.
- Clear:
  - An accepted clr_start sets clr_busy the next cycle and samples clr_data.
  - A clr_start arriving during a pen/host write is latched and starts after that write completes; that write still acks.
  - clr_start while clr_busy=1 is ignored (clr_data is not resampled).
  - The sweep index runs 0..63 row-major: row = idx[5:3], col = idx[2:0]. Each cell is one full IDLE/SETUP/STROBE/GAP sequence.
  - After the 64th write: clr_done pulses, clr_busy drops the cycle after, and the index returns to 0.
- Address conversion: one-hot = 8'h01 << binary. Exactly one bit is set at all times.
- req may drop without ack only while not granted; dropping after grant is a protocol violation and the write still completes.

Test Plan:
- Reset: hold rst 2 cycles -> ram_we=0, ram_addr_row=ram_addr_col=8'h01, clr_busy=0, no acks.
- Single pen write: pen_req with row=3, col=5, data=4'hA at cycle 0 ->
  - ram_addr_row=8'h08 and ram_addr_col=8'h20 from cycle 1;
  - ram_we=1 in cycle 2 only;
  - pen_ack in cycle 3;
  - RAM cell[3][5] reads 4'hA.
- Round-robin: pen and host both held high for 4 writes -> grants alternate pen, host, pen, host. Each ack arrives 4 cycles apart, and every RAM cell written matches the granted source's data.
- Clear with contention: clr_start (clr_data=4'h7) while host is mid-STROBE ->
  - host write completes and acks;
  - then 64 clear writes with no pen/host acks;
  - clr_done pulses once, about 256 cycles later;
  - every RAM cell reads 4'h7.
- Parameters WE_CYCLES=3, GAP_CYCLES=2: ram_we is high for exactly 3 consecutive cycles and low for 2 before IDLE; ack lands in the second GAP cycle.
- Reset mid-clear: assert rst at clear index 20 -> clr_busy=0 and ram_we=0 after the edge, no clr_done. A new clr_start restarts the sweep at index 0.

Source files
------------

// File: rtl/led_ram_wr_arb.sv
// Write-port controller for the 8x8x4 LED frame RAM: arbitrates pen, host and
// clear-sweep writers and generates the RAM's edge-sensitive write strobe.
`timescale 1ns/1ps
module led_ram_wr_arb #(
  parameter int WE_CYCLES  = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pen_req,
  input  logic [2:0] pen_row,
  input  logic [2:0] pen_col,
  input  logic [3:0] pen_data,
  output logic       pen_ack,
  input  logic       host_req,
  input  logic [2:0] host_row,
  input  logic [2:0] host_col,
  input  logic [3:0] host_data,
  output logic       host_ack,
  input  logic       clr_start,
  input  logic [3:0] clr_data,
  output logic       clr_busy,
  output logic       clr_done,
  output logic [3:0] ram_data,
  output logic [7:0] ram_addr_row,
  output logic [7:0] ram_addr_col,
  output logic       ram_we
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] WE_LAST  = CNT_W'(WE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;
  typedef enum logic [1:0] {SRC_PEN, SRC_HOST, SRC_CLR} src_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  src_t             src;
  logic             rr_pen;
  logic [5:0]       clr_idx;
  logic [3:0]       clr_val;
  logic             grant_pen, grant_host, grant_clr;
  logic             last_gap;

  function automatic logic [7:0] to_onehot(input logic [2:0] b);
    to_onehot = 8'h01 << b;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Clear beats pen/host; pen vs host alternates when both are waiting.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    grant_pen  = 1'b0;
    grant_host = 1'b0;
    grant_clr  = 1'b0;
    last_gap   = 1'b0;
    ram_we     = 1'b0;
    pen_ack    = 1'b0;
    host_ack   = 1'b0;
    clr_done   = 1'b0;
    case (state)
      IDLE: begin
        if (clr_busy) begin
          grant_clr  = 1'b1;
          state_next = SETUP;
        end else if (pen_req && (!host_req || rr_pen)) begin
          grant_pen  = 1'b1;
          state_next = SETUP;
        end else if (host_req) begin
          grant_host = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        cnt_next   = '0;
        state_next = STROBE;
      end
      STROBE: begin
        ram_we = 1'b1;
        if (cnt == WE_LAST) begin
          cnt_next   = '0;
          state_next = GAP;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          last_gap   = 1'b1;
          state_next = IDLE;
          pen_ack    = (src == SRC_PEN);
          host_ack   = (src == SRC_HOST);
          clr_done   = (src == SRC_CLR) && (clr_idx == 6'd63);
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_data     <= '0;
      ram_addr_row <= 8'h01;
      ram_addr_col <= 8'h01;
      rr_pen       <= 1'b1;
      clr_busy     <= 1'b0;
      clr_idx      <= '0;
      clr_val      <= '0;
      src          <= SRC_PEN;
    end else begin
      if (clr_start && !clr_busy) begin
        clr_busy <= 1'b1;
        clr_val  <= clr_data;
      end
      if (grant_clr) begin
        src          <= SRC_CLR;
        ram_addr_row <= to_onehot(clr_idx[5:3]);
        ram_addr_col <= to_onehot(clr_idx[2:0]);
        ram_data     <= clr_val;
      end else if (grant_pen) begin
        src          <= SRC_PEN;
        rr_pen       <= 1'b0;
        ram_addr_row <= to_onehot(pen_row);
        ram_addr_col <= to_onehot(pen_col);
        ram_data     <= pen_data;
      end else if (grant_host) begin
        src          <= SRC_HOST;
        rr_pen       <= 1'b1;
        ram_addr_row <= to_onehot(host_row);
        ram_addr_col <= to_onehot(host_col);
        ram_data     <= host_data;
      end
      // Sweep advances only once a clear cell's write has fully committed.
      if (last_gap && src == SRC_CLR) begin
        if (clr_idx == 6'd63) begin
          clr_idx  <= '0;
          clr_busy <= 1'b0;
        end else begin
          clr_idx <= clr_idx + 1'b1;
        end
      end
    end
  end

endmodule
